// File: rtl/cv32e40p_obi_arbiter.sv
// ============================================================================
//  Module      : cv32e40p_obi_arbiter
//  Description : 2-to-1 OBI arbiter. It shares one memory port between the
//                instruction-fetch master and the load/store data master.
//                Address phases are sequenced onto the shared port. Accepted
//                transfers are tracked in an in-order ID queue, so that each
//                response goes back to the master that issued it.
//  Ports       : clk, rst_n             - clock, asynchronous active-low reset
//                instr_*                - instruction master (read-only)
//                data_*                 - data master
//                obi_*                  - shared memory port
//  Config      : CV32E40P_OBI_ARB_ROUND_ROBIN_EN
//                  defined   -> round-robin arbitration
//                  undefined -> fixed priority, data beats instruction
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module cv32e40p_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        obi_req_o,
    input  logic        obi_gnt_i,
    output logic [31:0] obi_addr_o,
    output logic        obi_we_o,
    output logic [3:0]  obi_be_o,
    output logic [31:0] obi_wdata_o,
    input  logic        obi_rvalid_i,
    input  logic [31:0] obi_rdata_i,
    input  logic        obi_err_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    localparam logic ID_INSTR = 1'b0;
    localparam logic ID_DATA  = 1'b1;

    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q, id_fifo_d;
    logic                       locked_q, locked_d;
    logic                       locked_id_q, locked_id_d;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
    logic                       rr_q, rr_d;   // ID favoured on a tie
`endif

    logic full;
    logic sel;        // ID of the master currently driving the shared port
    logic push;
    logic pop;
    logic head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration and address-phase mux
    // ------------------------------------------------------------------
    always_comb begin
        full = (count_q == CNT_FULL);

        // A stalled address phase must not change until it is granted.
        // For this reason the lock overrides the arbitration policy.
        if (locked_q) begin
            sel = locked_id_q;
        end else if (instr_req_i && data_req_i) begin
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
            sel = rr_q;
`else
            sel = ID_DATA;
`endif
        end else if (data_req_i) begin
            sel = ID_DATA;
        end else begin
            sel = ID_INSTR;
        end

        // The full gate depends only on the registered count. It does not
        // depend on obi_rvalid_i, so there is no combinational rvalid->req path.
        obi_req_o   = (instr_req_i | data_req_i) & ~full;
        instr_gnt_o = obi_req_o & obi_gnt_i & (sel == ID_INSTR);
        data_gnt_o  = obi_req_o & obi_gnt_i & (sel == ID_DATA);

        if (sel == ID_DATA) begin
            obi_addr_o  = data_addr_i;
            obi_we_o    = data_we_i;
            obi_be_o    = data_be_i;
            obi_wdata_o = data_wdata_i;
        end else begin
            obi_addr_o  = instr_addr_i;
            obi_we_o    = 1'b0;
            obi_be_o    = 4'b1111;
            obi_wdata_o = 32'h0;
        end
    end

    // ------------------------------------------------------------------
    // Response routing. A response arriving with an empty queue is dropped.
    // ------------------------------------------------------------------
    always_comb begin
        head_id        = id_fifo_q[rd_ptr_q];
        pop            = obi_rvalid_i & (count_q != '0);
        instr_rvalid_o = pop & (head_id == ID_INSTR);
        data_rvalid_o  = pop & (head_id == ID_DATA);
        instr_err_o    = instr_rvalid_o & obi_err_i;
        data_err_o     = data_rvalid_o & obi_err_i;
        instr_rdata_o  = obi_rdata_i;
        data_rdata_o   = obi_rdata_i;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        push        = obi_req_o & obi_gnt_i;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        id_fifo_d   = id_fifo_q;
        locked_d    = locked_q;
        locked_id_d = locked_id_q;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
        rr_d        = rr_q;
`endif

        if (push) begin
            id_fifo_d[wr_ptr_q] = sel;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
            rr_d                = ~sel;
`endif
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        // A push is never possible while full, so the count cannot overflow.
        // A pop is never possible while empty, so the count cannot underflow.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // obi_req_o is already zero when full, so no lock can start then.
        if (obi_req_o && !obi_gnt_i) begin
            locked_d    = 1'b1;
            locked_id_d = sel;
        end else if (obi_gnt_i) begin
            locked_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            id_fifo_q   <= '0;
            locked_q    <= 1'b0;
            locked_id_q <= ID_INSTR;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
            rr_q        <= ID_DATA;
`endif
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            id_fifo_q   <= id_fifo_d;
            locked_q    <= locked_d;
            locked_id_q <= locked_id_d;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
            rr_q        <= rr_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_obi_arbiter.sv
// ============================================================================
//  Module      : tb_cv32e40p_obi_arbiter
//  Description : Self-checking bench for cv32e40p_obi_arbiter. A table of
//                per-cycle vectors is applied, and then a few hand-written
//                sequences follow. Each granted transfer pushes the expected
//                master ID into a scoreboard queue. Responses pop that queue.
//  Revision    : 1.0 - initial release
// ============================================================================

`default_nettype none

module tb_cv32e40p_obi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_gnt_o, data_we_i, data_rvalid_o, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;

    always #5 clk = ~clk;

    cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_addr_i   (instr_addr_i),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_wdata_i   (data_wdata_i),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .obi_req_o      (obi_req_o),
        .obi_gnt_i      (obi_gnt_i),
        .obi_addr_o     (obi_addr_o),
        .obi_we_o       (obi_we_o),
        .obi_be_o       (obi_be_o),
        .obi_wdata_o    (obi_wdata_o),
        .obi_rvalid_i   (obi_rvalid_i),
        .obi_rdata_i    (obi_rdata_i),
        .obi_err_i      (obi_err_i)
    );

    typedef struct {
        logic        ir, dr;
        logic [31:0] ia, da;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] dwd;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        er;
        logic        e_oreq, e_ig, e_dg;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    int   checks = 0;
    int   errors = 0;
    logic sb [$];      // expected master ID per outstanding transfer (1 = data)

    function automatic vec_t v(input logic ir, input logic dr,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic gnt, input logic rv,
                               input logic [31:0] rd, input logic er,
                               input logic e_oreq, input logic e_ig,
                               input logic e_dg, input logic [31:0] e_addr);
        vec_t t;
        t.ir = ir;  t.dr = dr;  t.ia = ia;  t.da = da;
        t.dwe = 1'b0; t.dbe = 4'hF; t.dwd = 32'h0;
        t.gnt = gnt; t.rv = rv; t.rd = rd; t.er = er;
        t.e_oreq = e_oreq; t.e_ig = e_ig; t.e_dg = e_dg; t.e_addr = e_addr;
        t.e_we = 1'b0; t.e_be = 4'hF; t.e_wd = 32'h0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_addr_i = 0; data_we_i = 0; data_be_i = 0; data_wdata_i = 0;
        obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; obi_err_i = 0;
    endtask

    // One clock cycle. Drive after the falling edge and check 1 ns later.
    // The rising edge then commits the cycle.
    task automatic step(input vec_t t);
        logic has;
        logic exp_id;
        @(negedge clk);
        instr_req_i  = t.ir;  instr_addr_i = t.ia;
        data_req_i   = t.dr;  data_addr_i  = t.da;
        data_we_i    = t.dwe; data_be_i    = t.dbe; data_wdata_i = t.dwd;
        obi_gnt_i    = t.gnt; obi_rvalid_i = t.rv;
        obi_rdata_i  = t.rd;  obi_err_i    = t.er;
        #1;
        chk("obi_req", {31'b0, obi_req_o}, {31'b0, t.e_oreq});
        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, t.e_ig});
        chk("data_gnt", {31'b0, data_gnt_o}, {31'b0, t.e_dg});
        if (t.e_oreq) begin
            chk("obi_addr", obi_addr_o, t.e_addr);
            chk("obi_we", {31'b0, obi_we_o}, {31'b0, t.e_we});
            chk("obi_be", {28'b0, obi_be_o}, {28'b0, t.e_be});
            chk("obi_wdata", obi_wdata_o, t.e_wd);
        end
        has    = t.rv && (sb.size() > 0);
        exp_id = 1'b0;
        if (has) exp_id = sb.pop_front();
        chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, has && !exp_id});
        chk("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, has && exp_id});
        chk("instr_err", {31'b0, instr_err_o}, {31'b0, has && !exp_id && t.er});
        chk("data_err", {31'b0, data_err_o}, {31'b0, has && exp_id && t.er});
        if (t.rv) begin
            chk("instr_rdata", instr_rdata_o, t.rd);
            chk("data_rdata", data_rdata_o, t.rd);
        end
        if (t.e_ig) sb.push_back(1'b0);
        if (t.e_dg) sb.push_back(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        //          ir dr ia        da          g  rv rd            er  oreq ig dg addr
        // Single fetch
        tbl[0]  = v(1, 0, 32'h80,  32'h0,    1, 0, 32'h0,       0,  1, 1, 0, 32'h80);
        tbl[1]  = v(0, 0, 32'h0,   32'h0,    0, 0, 32'h0,       0,  0, 0, 0, 32'h0);
        tbl[2]  = v(0, 0, 32'h0,   32'h0,    0, 1, 32'h13,      0,  0, 0, 0, 32'h0);
        // Lock: data stalls for three cycles while instr also asks
        tbl[3]  = v(0, 1, 32'h0,   32'h1000, 0, 0, 32'h0,       0,  1, 0, 0, 32'h1000);
        tbl[4]  = v(1, 1, 32'h84,  32'h1000, 0, 0, 32'h0,       0,  1, 0, 0, 32'h1000);
        tbl[5]  = v(1, 1, 32'h84,  32'h1000, 0, 0, 32'h0,       0,  1, 0, 0, 32'h1000);
        tbl[6]  = v(1, 1, 32'h84,  32'h1000, 1, 0, 32'h0,       0,  1, 0, 1, 32'h1000);
        tbl[7]  = v(1, 0, 32'h84,  32'h0,    1, 0, 32'h0,       0,  1, 1, 0, 32'h84);
        // Full: two outstanding, so requests are held off even on rvalid
        tbl[8]  = v(1, 1, 32'h88,  32'h1004, 1, 0, 32'h0,       0,  0, 0, 0, 32'h0);
        tbl[9]  = v(1, 1, 32'h88,  32'h1004, 1, 1, 32'hAAAA,    1,  0, 0, 0, 32'h0);
        tbl[10] = v(1, 0, 32'h88,  32'h0,    1, 0, 32'h0,       0,  1, 1, 0, 32'h88);
        tbl[11] = v(0, 0, 32'h0,   32'h0,    0, 1, 32'hBBBB,    0,  0, 0, 0, 32'h0);
        tbl[12] = v(0, 0, 32'h0,   32'h0,    0, 1, 32'hCCCC,    1,  0, 0, 0, 32'h0);
        // Ordering and error: I then D (D is a write)
        tbl[13] = v(1, 0, 32'h90,  32'h0,    1, 0, 32'h0,       0,  1, 1, 0, 32'h90);
        tbl[14] = v(0, 1, 32'h0,   32'h2000, 1, 0, 32'h0,       0,  1, 0, 1, 32'h2000);
        tbl[14].dwe = 1'b1; tbl[14].dbe = 4'h3; tbl[14].dwd = 32'hCAFEBABE;
        tbl[14].e_we = 1'b1; tbl[14].e_be = 4'h3; tbl[14].e_wd = 32'hCAFEBABE;
        tbl[15] = v(0, 0, 32'h0,   32'h0,    0, 1, 32'h1111,    1,  0, 0, 0, 32'h0);
        tbl[16] = v(0, 0, 32'h0,   32'h0,    0, 1, 32'h2222,    0,  0, 0, 0, 32'h0);
        // Stray rvalid, then confirm the count stayed at zero
        tbl[17] = v(0, 0, 32'h0,   32'h0,    0, 1, 32'hDEAD,    1,  0, 0, 0, 32'h0);
        tbl[18] = v(1, 0, 32'h94,  32'h0,    1, 0, 32'h0,       0,  1, 1, 0, 32'h94);
        tbl[19] = v(0, 0, 32'h0,   32'h0,    0, 1, 32'h13,      0,  0, 0, 0, 32'h0);

        zero_inputs();
        rst_n = 1'b0;
        // Reset state: nothing granted, and a response is ignored
        step(v(0, 0, 32'h0, 32'h0, 1, 1, 32'h5A5A, 1, 0, 0, 0, 32'h0));
        zero_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) step(tbl[i]);

        // Contention: both masters request every cycle with gnt=1
        for (int k = 0; k < 4; k++) begin
            vec_t t;
            logic win_d;
`ifdef CV32E40P_OBI_ARB_ROUND_ROBIN_EN
            win_d = (k % 2 == 0);
`else
            win_d = 1'b1;
`endif
            t = v(1, 1, 32'h100 + k, 32'h200 + k, 1, (k > 0), 32'h1000 + k, 0,
                  1, !win_d, win_d, win_d ? 32'h200 + k : 32'h100 + k);
            step(t);
        end
        step(v(0, 0, 32'h0, 32'h0, 0, 1, 32'h77, 0, 0, 0, 0, 32'h0));

        // Reset mid-transfer: one data transfer is outstanding and a data
        // lock is held. Both must be gone after reset.
        step(v(0, 1, 32'h0, 32'h3000, 1, 0, 32'h0, 0, 1, 0, 1, 32'h3000));
        step(v(0, 1, 32'h0, 32'h3004, 0, 0, 32'h0, 0, 1, 0, 0, 32'h3004));
        do_reset();
        step(v(1, 0, 32'hA0, 32'h0, 1, 1, 32'h55, 0, 1, 1, 0, 32'hA0));
        step(v(0, 0, 32'h0, 32'h0, 0, 1, 32'h66, 0, 0, 0, 0, 32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cv32e40p_obi_arbiter.md
Name: cv32e40p_obi_arbiter

Overview:
- 2-to-1 OBI arbiter that shares a single memory port between the instruction-fetch OBI master (prefetch buffer side) and the data OBI master (load/store side).
- Used in single-port memory configurations.
- Sequences address phases onto the shared port and tracks outstanding transactions in an in-order ID queue.
- Routes each response phase back to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2, number of accepted-but-unanswered transactions on the shared port; ID-queue depth; power of 2, >= 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_req_i  in  1  instruction master address-phase request
- instr_gnt_o  out  1  instruction master grant
- instr_addr_i  in  32  instruction master address
- instr_rvalid_o  out  1  instruction master response valid
- instr_rdata_o  out  32  instruction master read data
- instr_err_o  out  1  instruction master bus error
- data_req_i  in  1  data master request
- data_gnt_o  out  1  data master grant
- data_addr_i  in  32  data master address
- data_we_i  in  1  data master write enable
- data_be_i  in  4  data master byte enables
- data_wdata_i  in  32  data master write data
- data_rvalid_o  out  1  data master response valid
- data_rdata_o  out  32  data master read data
- data_err_o  out  1  data master bus error
- obi_req_o  out  1  shared port request
- obi_gnt_i  in  1  shared port grant
- obi_addr_o  out  32  shared port address
- obi_we_o  out  1  shared port write enable
- obi_be_o  out  4  shared port byte enables
- obi_wdata_o  out  32  shared port write data
- obi_rvalid_i  in  1  shared port response valid
- obi_rdata_i  in  32  shared port read data
- obi_err_i  in  1  shared port error

Behaviour:
- Reset:
  - All 1-bit outputs 0; obi_addr_o/obi_be_o/obi_wdata_o driven from the instruction master mux path (don't-care while obi_req_o=0).
  - ID queue empty; lock cleared; round-robin pointer favours data.
- Instruction transfers on the shared port: we=0, be=4'b1111, wdata=0.
- Arbitration, combinational, when not locked and queue not full:
  - Winner chosen among asserted requests by the policy (see Optional Feature).
  - obi_req_o = instr_req_i | data_req_i.
  - Shared-port address-phase signals muxed from the winner.
  - Winner's gnt_o = obi_gnt_i; loser's gnt_o = 0.
- Lock:
  - If obi_req_o=1 and obi_gnt_i=0, set locked_q and store locked_id_q = winner.
  - While locked, the selection stays on locked_id_q regardless of the other request. OBI forbids changing the address phase before gnt.
  - Lock clears in the cycle obi_gnt_i=1.
- ID queue:
  - Push the winner ID on obi_req_o & obi_gnt_i.
  - Pop on obi_rvalid_i.
  - Simultaneous push and pop keeps the count.
- Full:
  - When count == MAX_OUTSTANDING: obi_req_o=0 and both gnt_o=0, even if obi_rvalid_i=1 that cycle. There is no combinational path rvalid->req.
  - Lock is never set while full. A locked transfer was started while not full, so it can still complete.
- Response routing, same cycle, zero latency:
  - instr_rvalid_o = obi_rvalid_i & (head ID == instr).
  - data_rvalid_o = obi_rvalid_i & (head ID == data).
  - rdata is broadcast to both masters.
  - err is gated like rvalid.
- obi_rvalid_i with an empty queue: illegal; response dropped, no master sees rvalid, count stays 0.
- Responses are strictly in order; count is held in clog2(MAX_OUTSTANDING)+1 bits and never wraps.
- Reset mid-transfer: queue, lock and pointer return to reset values immediately. Any in-flight response is lost; the system resets the memory too.

Optional Feature:
- Macro CV32E40P_OBI_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin; pointer flips to the other master after every granted transfer.
  - On simultaneous requests, the master indicated by the pointer wins.
- Undefined: fixed priority, data beats instruction; the pointer register is removed.
- Lock, queue and full behaviour are identical in both builds.

Test Plan:
- Single fetch:
  - Stimulus: instr_req=1, addr=0x80; obi_gnt=1 in cycle 0; obi_rvalid=1, rdata=0x00000013 in cycle 2.
  - Required response: instr_gnt=1 in cycle 0; obi_addr=0x80, we=0; instr_rvalid=1, rdata=0x13 in cycle 2; data_rvalid stays 0.
- Lock:
  - Stimulus: data_req=1, addr=0x1000; obi_gnt=0 for 3 cycles; instr_req rises in cycle 1.
  - Required response: obi_addr stays 0x1000 until gnt; instr_gnt=0 throughout; the instr request is issued in the cycle after the data gnt.
- Contention:
  - Stimulus: both masters request continuously with gnt=1.
  - Required response, fixed build: data granted every cycle.
  - Required response, ROUND_ROBIN_EN build: grants alternate D,I,D,I.
- Full:
  - Stimulus: MAX_OUTSTANDING=2; two grants issued with no rvalid.
  - Required response: obi_req=0 with requests pending. After one rvalid, obi_req=1 again in the next cycle.
- Ordering and error:
  - Stimulus: issue I then D; rvalid with err=1, then rvalid with err=0.
  - Required response: instr_err=1 on the first response; data_rvalid=1, data_err=0 on the second.
- Stray rvalid:
  - Stimulus: obi_rvalid=1 while the queue is empty.
  - Required response: both rvalid outputs 0; count stays 0.
